uart_tx: RTL and testbench

- 8N1 serial transmitter: the transmit-side counterpart of the computer's uart_rx path.
- The CPU bus side pushes bytes into a small FIFO. A bit-timing state machine serialises them onto the tx line, LSB first.
- Raises a one-cycle done pulse per frame for the interrupt logic, and a level flag while the FIFO is empty.

---
 rtl/uart_tx_if.sv | 27 ++
 rtl/uart_tx.sv | 173 +++++++++++++++++
 tb/tb_uart_tx.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// Write-side bus of the UART transmitter.
// Handshake: the byte on wr_data is taken on a rising clk edge where
// wr_en && !full; a wr_en seen while full drops the byte and raises overflow
// for the following cycle. There is no back-pressure beyond full.
interface uart_tx_if;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic       overflow;

  modport master (
    output wr_en,
    output wr_data,
    input  full,
    input  empty,
    input  overflow
  );

  modport slave (
    input  wr_en,
    input  wr_data,
    output full,
    output empty,
    output overflow
  );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: a small byte FIFO feeding a bit-timing state machine
// that shifts each byte out LSB first between a start bit and a stop bit.
module uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_AW      = 2
) (
  input  logic       clk,
  input  logic       reset,
  uart_tx_if.slave   bus,
  output logic       busy,
  output logic       tx_done,
  output logic       tx,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]    CNT_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0] COUNT_FULL = (FIFO_AW + 1)'(DEPTH);

  // FIFO storage and bookkeeping
  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;
  logic               overflow_q, overflow_d;
  logic               wr_accept;
  logic               pop;

  // Serialiser state
  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         idx_q, idx_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;

  // FIFO next-state: pointer advance, occupancy and registered flags
  always_comb begin
    wr_accept  = bus.wr_en && !full_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (wr_accept) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
    if (pop)       rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    count_d    = count_q + (FIFO_AW + 1)'(wr_accept) - (FIFO_AW + 1)'(pop);
    full_d     = (count_d == COUNT_FULL);
    empty_d    = (count_d == '0);
    // A write while full is dropped even if a pop frees a slot on this edge.
    overflow_d = bus.wr_en && full_q;
  end

  // FIFO data array: written on accepted pushes only, no reset needed
  always_ff @(posedge clk) begin
    if (wr_accept) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  // FIFO control registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  // Serialiser next-state: bit timing, shifting, pops and next tx level
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty_q) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          cnt_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          idx_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          // Chain straight into the next start bit when a byte is waiting.
          if (!empty_q) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // tx is registered, so its next value follows the next state.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // Serialiser registers; reset forces the line high immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign bus.full     = full_q;
  assign bus.empty    = empty_q;
  assign bus.overflow = overflow_q;
  assign busy         = (state_q != S_IDLE);
  assign tx_done      = (state_q == S_STOP) && (cnt_q == CNT_LAST);
  assign tx           = tx_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: one 16-clock/bit instance and one 2-clock/bit
// instance sharing clock and reset.
module tb_uart_tx;

  logic clk = 1'b0;
  logic reset;

  // 10 ns clock
  always #5 clk = ~clk;

  uart_tx_if bus_a ();
  uart_tx_if bus_b ();

  logic       busy_a, done_a, tx_a;
  logic       busy_b, done_b, tx_b;
  logic [1:0] st_a, st_b;

  uart_tx #(.CLKS_PER_BIT(16), .FIFO_AW(2)) dut_a (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_a),
    .busy      (busy_a),
    .tx_done   (done_a),
    .tx        (tx_a),
    .state_dbg (st_a)
  );

  uart_tx #(.CLKS_PER_BIT(2), .FIFO_AW(2)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_b),
    .busy      (busy_b),
    .tx_done   (done_b),
    .tx        (tx_b),
    .state_dbg (st_b)
  );

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt_a = 0;
  int done_cnt_b = 0;
  int ovf_cnt_a  = 0;

  // Pulse counters sampled mid-cycle
  always @(negedge clk) begin
    if (done_a === 1'b1)         done_cnt_a++;
    if (done_b === 1'b1)         done_cnt_b++;
    if (bus_a.overflow === 1'b1) ovf_cnt_a++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Walks one frame cycle by cycle from offset start_off, checking tx and
  // tx_done; optionally presents a write on the frame's final edge.
  task automatic check_frame(input string tag, input bit use_b, input logic [7:0] b,
                             input int cpb, input int start_off,
                             input bit push_last, input logic [7:0] nb);
    logic exp_tx;
    logic obs_tx;
    logic obs_done;
    int   bit_i;
    for (int i = start_off; i < 10 * cpb; i++) begin
      bit_i = i / cpb;
      if (bit_i == 0)      exp_tx = 1'b0;
      else if (bit_i == 9) exp_tx = 1'b1;
      else                 exp_tx = b[bit_i-1];
      obs_tx   = use_b ? tx_b   : tx_a;
      obs_done = use_b ? done_b : done_a;
      chk({tag, " tx"}, {31'd0, obs_tx}, {31'd0, exp_tx});
      chk({tag, " tx_done"}, {31'd0, obs_done}, (i == 10 * cpb - 1) ? 32'd1 : 32'd0);
      if (push_last && i == 10 * cpb - 1) begin
        bus_a.wr_en   = 1'b1;
        bus_a.wr_data = nb;
      end
      tick();
    end
    bus_a.wr_en = 1'b0;
  endtask

  int d0;
  bit tx_glitch;

  initial begin
    reset         = 1'b1;
    bus_a.wr_en   = 1'b0;
    bus_a.wr_data = 8'h00;
    bus_b.wr_en   = 1'b0;
    bus_b.wr_data = 8'h00;
    repeat (3) tick();

    // Reset values
    chk("rst tx",       {31'd0, tx_a},           32'd1);
    chk("rst busy",     {31'd0, busy_a},         32'd0);
    chk("rst tx_done",  {31'd0, done_a},         32'd0);
    chk("rst overflow", {31'd0, bus_a.overflow}, 32'd0);
    chk("rst full",     {31'd0, bus_a.full},     32'd0);
    chk("rst empty",    {31'd0, bus_a.empty},    32'd1);
    chk("rst state",    {30'd0, st_a},           32'd0);
    chk("rst b tx",     {31'd0, tx_b},           32'd1);
    chk("rst b empty",  {31'd0, bus_b.empty},    32'd1);
    chk("rst b full",   {31'd0, bus_b.full},     32'd0);
    reset = 1'b0;
    tick();

    // 1: single byte 0x55
    bus_a.wr_en = 1'b1; bus_a.wr_data = 8'h55;
    tick();
    bus_a.wr_en = 1'b0;
    chk("t1 empty after write", {31'd0, bus_a.empty}, 32'd0);
    chk("t1 idle before pop",   {31'd0, busy_a},      32'd0);
    chk("t1 tx before pop",     {31'd0, tx_a},        32'd1);
    tick();
    chk("t1 busy at start",     {31'd0, busy_a},      32'd1);
    chk("t1 empty after pop",   {31'd0, bus_a.empty}, 32'd1);
    d0 = done_cnt_a;
    check_frame("t1", 1'b0, 8'h55, 16, 0, 1'b0, 8'h00);
    chk("t1 busy after",  {31'd0, busy_a}, 32'd0);
    chk("t1 tx after",    {31'd0, tx_a},   32'd1);
    chk("t1 state after", {30'd0, st_a},   32'd0);
    chk("t1 done count",  done_cnt_a - d0, 32'd1);

    // 2: back-to-back 0xA3, 0x0F
    bus_a.wr_en = 1'b1; bus_a.wr_data = 8'hA3;
    tick();
    bus_a.wr_data = 8'h0F;
    tick();
    bus_a.wr_en = 1'b0; bus_a.wr_data = 8'hEE;
    chk("t2 second queued", {31'd0, bus_a.empty}, 32'd0);
    d0 = done_cnt_a;
    check_frame("t2 a3", 1'b0, 8'hA3, 16, 0, 1'b0, 8'h00);
    chk("t2 no idle gap", {30'd0, st_a}, 32'd1);
    check_frame("t2 0f", 1'b0, 8'h0F, 16, 0, 1'b0, 8'h00);
    chk("t2 done count", done_cnt_a - d0, 32'd2);
    chk("t2 busy after", {31'd0, busy_a}, 32'd0);

    // 3: fill the FIFO and overflow it
    d0 = done_cnt_a;
    bus_a.wr_en = 1'b1; bus_a.wr_data = 8'h11; tick();
    bus_a.wr_data = 8'h22; tick();
    bus_a.wr_data = 8'h33; tick();
    bus_a.wr_data = 8'h44; tick();
    bus_a.wr_data = 8'h55; tick();
    chk("t3 full", {31'd0, bus_a.full}, 32'd1);
    chk("t3 no overflow yet", {31'd0, bus_a.overflow}, 32'd0);
    bus_a.wr_data = 8'h66; tick();
    bus_a.wr_en = 1'b0; bus_a.wr_data = 8'h00;
    chk("t3 overflow pulse", {31'd0, bus_a.overflow}, 32'd1);
    chk("t3 still full",     {31'd0, bus_a.full},     32'd1);
    tick();
    chk("t3 overflow cleared", {31'd0, bus_a.overflow}, 32'd0);
    check_frame("t3 f11", 1'b0, 8'h11, 16, 5, 1'b0, 8'h00);
    chk("t3 full dropped", {31'd0, bus_a.full}, 32'd0);
    check_frame("t3 f22", 1'b0, 8'h22, 16, 0, 1'b0, 8'h00);
    check_frame("t3 f33", 1'b0, 8'h33, 16, 0, 1'b0, 8'h00);
    check_frame("t3 f44", 1'b0, 8'h44, 16, 0, 1'b0, 8'h00);
    chk("t3 empty after last pop", {31'd0, bus_a.empty}, 32'd1);
    check_frame("t3 f55", 1'b0, 8'h55, 16, 0, 1'b0, 8'h00);
    chk("t3 busy after", {31'd0, busy_a}, 32'd0);
    repeat (20) tick();
    chk("t3 no 0x66 frame", {31'd0, tx_a}, 32'd1);
    chk("t3 done count", done_cnt_a - d0, 32'd5);
    chk("t3 overflow count", ovf_cnt_a, 32'd1);

    // 4: reset mid-DATA with two bytes queued
    bus_a.wr_en = 1'b1; bus_a.wr_data = 8'hC1; tick();
    bus_a.wr_data = 8'hC2; tick();
    bus_a.wr_data = 8'hC3; tick();
    bus_a.wr_en = 1'b0;
    repeat (30) tick();
    chk("t4 in data", {30'd0, st_a}, 32'd2);
    reset = 1'b1;
    #1;
    chk("t4 async tx",      {31'd0, tx_a},        32'd1);
    chk("t4 async busy",    {31'd0, busy_a},      32'd0);
    chk("t4 async empty",   {31'd0, bus_a.empty}, 32'd1);
    chk("t4 async full",    {31'd0, bus_a.full},  32'd0);
    chk("t4 async tx_done", {31'd0, done_a},      32'd0);
    tick();
    tick();
    reset = 1'b0;
    d0 = done_cnt_a;
    tx_glitch = 1'b0;
    repeat (400) begin
      tick();
      if (tx_a !== 1'b1) tx_glitch = 1'b1;
    end
    chk("t4 no frame after reset", {31'd0, tx_glitch}, 32'd0);
    chk("t4 no tx_done",           done_cnt_a - d0,    32'd0);
    chk("t4 idle",                 {31'd0, busy_a},    32'd0);

    // 5: write lands on the edge the previous stop bit ends
    bus_a.wr_en = 1'b1; bus_a.wr_data = 8'h3C; tick();
    bus_a.wr_en = 1'b0;
    tick();
    check_frame("t5 prev", 1'b0, 8'h3C, 16, 0, 1'b1, 8'h81);
    bus_a.wr_data = 8'h00;
    chk("t5 idle one cycle", {30'd0, st_a},        32'd0);
    chk("t5 busy low",       {31'd0, busy_a},      32'd0);
    chk("t5 tx high",        {31'd0, tx_a},        32'd1);
    chk("t5 byte queued",    {31'd0, bus_a.empty}, 32'd0);
    tick();
    chk("t5 start state", {30'd0, st_a}, 32'd1);
    check_frame("t5 f81", 1'b0, 8'h81, 16, 0, 1'b0, 8'h00);
    chk("t5 busy after", {31'd0, busy_a}, 32'd0);

    // 6: two clocks per bit, 0xFF
    bus_b.wr_en = 1'b1; bus_b.wr_data = 8'hFF; tick();
    bus_b.wr_en = 1'b0;
    tick();
    chk("t6 start state", {30'd0, st_b}, 32'd1);
    d0 = done_cnt_b;
    check_frame("t6", 1'b1, 8'hFF, 2, 0, 1'b0, 8'h00);
    chk("t6 done count", done_cnt_b - d0, 32'd1);
    chk("t6 busy after", {31'd0, busy_b}, 32'd0);
    chk("t6 empty",      {31'd0, bus_b.empty}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
